// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant lasts until MAX_BURST beats are written or the requester drops Valid.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          W_CLK,
  input  logic                          W_RST,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ready,
  input  logic                          W_Full,
  output logic                          W_inc,
  output logic [DATA_WIDTH-1:0]         W_Data,
  output logic                          Grant_Vld,
  output logic [$clog2(NUM_REQ)-1:0]    Grant_Id
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_reg;
  logic              grant_vld_reg;
  logic [ID_W-1:0]   grant_id_reg;
  logic [ID_W-1:0]   last_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic [ID_W-1:0]       cand_id  [NUM_REQ];
  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;
  logic                  in_burst;
  logic                  beat;
  logic                  last_beat;

  // cand_id[k] is the k-th requester after the last grant, in priority order
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi] = Req_Data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign cand_id[gi]  = ID_W'((int'(last_reg) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // Scan from lowest priority up so the highest-priority valid candidate wins
  always_comb begin
    pick_found = 1'b0;
    pick_id    = last_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (Req_Valid[cand_id[k]]) begin
        pick_found = 1'b1;
        pick_id    = cand_id[k];
      end
    end
  end

  assign in_burst  = (state_reg == BURST);
  assign beat      = in_burst & Req_Valid[grant_id_reg] & ~W_Full;
  assign last_beat = (count_reg == CNT_LAST);

  always_comb begin
    Req_Ready = '0;
    if (in_burst) begin
      Req_Ready[grant_id_reg] = ~W_Full;
    end
  end

  assign W_inc     = beat;
  assign W_Data    = in_burst ? req_word[grant_id_reg] : '0;
  assign Grant_Vld = grant_vld_reg;
  assign Grant_Id  = grant_id_reg;

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      state_reg     <= IDLE;
      grant_vld_reg <= 1'b0;
      grant_id_reg  <= '0;
      last_reg      <= LAST_INIT;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg     <= BURST;
            grant_vld_reg <= 1'b1;
            grant_id_reg  <= pick_id;
            last_reg      <= pick_id;
            count_reg     <= '0;
          end
        end
        BURST: begin
          // A full FIFO only stalls the burst; it never ends it
          if (!Req_Valid[grant_id_reg] || (beat && last_beat)) begin
            state_reg     <= IDLE;
            grant_vld_reg <= 1'b0;
            count_reg     <= '0;
          end else if (beat) begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          grant_vld_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed requester traffic, expected
// beats queued in grant order, monitor pops and compares on every W_inc.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          W_CLK = 1'b0;
  logic                          W_RST = 1'b1;
  logic [NUM_REQ-1:0]            Req_Valid = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data = '0;
  logic [NUM_REQ-1:0]            Req_Ready;
  logic                          W_Full = 1'b0;
  logic                          W_inc;
  logic [DATA_WIDTH-1:0]         W_Data;
  logic                          Grant_Vld;
  logic [1:0]                    Grant_Id;

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .W_Full(W_Full), .W_inc(W_inc), .W_Data(W_Data),
    .Grant_Vld(Grant_Vld), .Grant_Id(Grant_Id)
  );

  always #5 W_CLK = ~W_CLK;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
  int remaining [NUM_REQ];
  int ptr [NUM_REQ];
  logic s_winc, s_gvld;
  logic [1:0] s_gid;
  logic [NUM_REQ-1:0] s_ready;

  function automatic logic [7:0] word(int r, int n);
    return 8'((r << 6) | (n & 63));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(int r, int n);
    exp_q.push_back({2'(r), word(r, n)});
  endtask

  function automatic bit pending();
    for (int r = 0; r < NUM_REQ; r++)
      if (remaining[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int r = 0; r < NUM_REQ; r++) begin
      Req_Valid[r] = (remaining[r] != 0);
      Req_Data[r*DATA_WIDTH +: DATA_WIDTH] = word(r, ptr[r]);
    end
  endtask

  // One clock: sample outputs mid-cycle, then advance requesters that handshook
  task automatic tick();
    logic [NUM_REQ-1:0] fire;
    @(negedge W_CLK);
    s_winc  = W_inc;
    s_gvld  = Grant_Vld;
    s_gid   = Grant_Id;
    s_ready = Req_Ready;
    fire    = Req_Valid & Req_Ready;
    @(posedge W_CLK);
    #1;
    for (int r = 0; r < NUM_REQ; r++)
      if (fire[r]) begin
        ptr[r]++;
        remaining[r]--;
      end
    drive();
  endtask

  task automatic do_reset();
    W_RST  = 1'b1;
    W_Full = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      remaining[r] = 0;
      ptr[r]       = 0;
    end
    drive();
    repeat (2) @(posedge W_CLK);
    @(negedge W_CLK);
    W_RST = 1'b0;
    @(posedge W_CLK);
    #1;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((pending() || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (pending() || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
    end
    tick();
    tick();
    check({name, "_idle"}, Grant_Vld, 0);
  endtask

  always @(negedge W_CLK) begin : monitor
    logic [9:0] e;
    if (W_RST) begin
      check("rst_winc", W_inc, 0);
    end else begin
      check("full_guard", W_inc & W_Full, 0);
      check("ready_map", Req_Ready,
            (Grant_Vld && !W_Full) ? (4'b0001 << Grant_Id) : 4'b0000);
      if (W_inc) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: id=%0d data=%02h, required no beat", Grant_Id, W_Data);
        end else begin
          e = exp_q.pop_front();
          $display("beat id=%0d data=%02h (expected id=%0d data=%02h)", Grant_Id, W_Data, e[9:8], e[7:0]);
          check("beat_id", Grant_Id, e[9:8]);
          check("beat_data", W_Data, e[7:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pat [10];
    pat = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

    // Reset state and quiet idle
    do_reset();
    check("rst_winc0", W_inc, 0);
    check("rst_gvld", Grant_Vld, 0);
    check("rst_gid", Grant_Id, 0);
    check("rst_ready", Req_Ready, 0);
    check("rst_wdata", W_Data, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_winc", s_winc, 0);
      check("idle_gvld", s_gvld, 0);
      check("idle_ready", s_ready, 0);
    end

    // Single requester: one arbitration bubble then MAX_BURST beats, repeating
    do_reset();
    for (int n = 0; n < 8; n++) push(0, n);
    remaining[0] = 8;
    drive();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t2_winc", s_winc, pat[k]);
      check("t2_gvld", s_gvld, pat[k]);
      if (pat[k] != 0) check("t2_gid", s_gid, 0);
    end
    drain("t2", 20);

    // All requesters: grants rotate 0,1,2,3,0,1,2,3
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NUM_REQ; r++)
        for (int n = 0; n < MAX_BURST; n++) push(r, b * MAX_BURST + n);
    for (int r = 0; r < NUM_REQ; r++) remaining[r] = 8;
    drive();
    drain("t3", 80);

    // Full stall mid-burst keeps the grant and resumes
    do_reset();
    for (int n = 0; n < 4; n++) push(2, n);
    remaining[2] = 4;
    drive();
    repeat (3) tick();
    check("t4_pre_beats", ptr[2], 2);
    W_Full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_winc", s_winc, 0);
      check("t4_ready", s_ready, 0);
      check("t4_gvld", s_gvld, 1);
      check("t4_gid", s_gid, 2);
    end
    W_Full = 1'b0;
    drain("t4", 20);

    // Requester drops Valid after one beat; pointer moves on to 2, 3, 0
    do_reset();
    push(1, 0);
    remaining[1] = 1;
    drive();
    tick();
    tick();
    remaining[0] = 1;
    remaining[2] = 1;
    remaining[3] = 1;
    push(2, 0);
    push(3, 0);
    push(0, 0);
    drive();
    tick();
    check("t5_exit_winc", s_winc, 0);
    check("t5_exit_gvld", s_gvld, 1);
    tick();
    check("t5_bubble_gvld", s_gvld, 0);
    drain("t5", 40);

    // Reset mid-burst: outputs drop at once, req 0 first after release
    do_reset();
    remaining[1] = 4;
    push(1, 0);
    push(1, 1);
    drive();
    repeat (3) tick();
    W_RST = 1'b1;
    #1;
    check("t6_winc", W_inc, 0);
    check("t6_ready", Req_Ready, 0);
    check("t6_gvld", Grant_Vld, 0);
    check("t6_gid", Grant_Id, 0);
    check("t6_wdata", W_Data, 0);
    check("t6_beats_before", exp_q.size(), 0);
    remaining[0] = 4;
    remaining[2] = 4;
    for (int n = 0; n < 4; n++) push(0, n);
    push(1, 2);
    push(1, 3);
    for (int n = 0; n < 4; n++) push(2, n);
    drive();
    @(negedge W_CLK);
    W_RST = 1'b0;
    @(posedge W_CLK);
    #1;
    drain("t6", 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
